// File: rtl/ctrl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle sequencer:
// state/class encodings, opcode patterns and ALUOp codes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   // ILLEGAL sits at zero so a cleared class register drives no controls
   typedef enum logic [2:0] {
      CLS_ILLEGAL = 3'd0,
      CLS_R       = 3'd1,
      CLS_LD      = 3'd2,
      CLS_ST      = 3'd3,
      CLS_CB      = 3'd4
   } class_t;

   localparam logic [10:0] OP_ADD   = 11'b100_0101_1000;
   localparam logic [10:0] OP_SUB   = 11'b110_0101_1000;
   localparam logic [10:0] OP_AND   = 11'b100_0101_0000;
   localparam logic [10:0] OP_ORR   = 11'b101_0101_0000;
   localparam logic [10:0] OP_LDUR  = 11'b111_1100_0010;
   localparam logic [10:0] OP_STUR  = 11'b111_1100_0000;
   localparam logic [10:0] OP_CBZ   = 11'b101_1010_0000;
   localparam logic [10:0] CBZ_MASK = 11'b111_1111_1000;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_CB  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode-to-instruction-class decoder for the multi-cycle sequencer.
module opcode_classifier
   import ctrl_pkg::*;
(
   input  logic [10:0] opcode,
   output class_t      cls
);

   always_comb begin
      cls = CLS_ILLEGAL;
      if ((opcode & CBZ_MASK) == OP_CBZ) begin
         cls = CLS_CB;
      end else begin
         case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: cls = CLS_R;
            OP_LDUR:                        cls = CLS_LD;
            OP_STUR:                        cls = CLS_ST;
            default:                        cls = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/multi_cycle_control.sv
// LEGv8 multi-cycle sequencer (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK) with a
// memory wait timeout. Define CTRL_PERF_EN to add the retired-instruction counter.
module multi_cycle_control
   import ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic [10:0] opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg_to_loc,
   output logic        alu_src,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  alu_op,
   output logic        busy,
   output logic        fault,
   output logic [2:0]  state
`ifdef CTRL_PERF_EN
   ,
   output logic [31:0] retired
`endif
);

   localparam int unsigned    CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   state_t        cur, nxt;
   class_t        cls_dec, cls_q, cls_use;
   logic [CW-1:0] wait_cnt;
   logic          timeout_hit;
   logic          end_instr;

   opcode_classifier u_classifier (
      .opcode (opcode),
      .cls    (cls_dec)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         cur      <= S_IDLE;
         cls_q    <= CLS_ILLEGAL;
         wait_cnt <= '0;
      end else begin
         cur <= nxt;
         if (cur == S_DECODE)
            cls_q <= cls_dec;
         if ((cur == S_FETCH || cur == S_MEMORY) && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
      end
   end

   // DECODE already shows the class controls, before the class is latched
   assign cls_use     = (cur == S_DECODE) ? cls_dec : cls_q;
   assign timeout_hit = !mem_ready && (wait_cnt == LAST);

   always_comb begin
      nxt        = cur;
      mem_req    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_to_loc = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_op     = ALUOP_MEM;
      end_instr  = 1'b0;

      if (cur == S_DECODE || cur == S_EXECUTE || cur == S_MEMORY || cur == S_WRITEBACK) begin
         case (cls_use)
            CLS_R:  alu_op = ALUOP_R;
            CLS_LD: alu_src = 1'b1;
            CLS_ST: begin alu_src = 1'b1; reg_to_loc = 1'b1; end
            CLS_CB: begin alu_op = ALUOP_CB; reg_to_loc = 1'b1; end
            default: ;
         endcase
      end

      case (cur)
         S_IDLE: if (run) nxt = S_FETCH;
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               nxt      = S_DECODE;
            end else if (timeout_hit) begin
               nxt = S_FAULT;
            end
         end
         S_DECODE: nxt = (cls_dec == CLS_ILLEGAL) ? S_FAULT : S_EXECUTE;
         S_EXECUTE: begin
            case (cls_q)
               CLS_R:         nxt = S_WRITEBACK;
               CLS_LD, CLS_ST: nxt = S_MEMORY;
               CLS_CB: begin
                  pc_write  = zero;
                  pc_src    = zero;
                  end_instr = 1'b1;
               end
               default:       nxt = S_FAULT;
            endcase
         end
         S_MEMORY: begin
            mem_req   = 1'b1;
            mem_read  = (cls_q == CLS_LD);
            mem_write = (cls_q == CLS_ST);
            if (mem_ready) begin
               if (cls_q == CLS_LD) nxt = S_WRITEBACK;
               else                 end_instr = 1'b1;
            end else if (timeout_hit) begin
               nxt = S_FAULT;
            end
         end
         S_WRITEBACK: begin
            reg_write  = 1'b1;
            mem_to_reg = (cls_q == CLS_LD);
            end_instr  = 1'b1;
         end
         S_FAULT: nxt = S_FAULT;
         default: nxt = S_IDLE;
      endcase

      if (end_instr)
         nxt = run ? S_FETCH : S_IDLE;
   end

   assign busy  = (cur != S_IDLE) && (cur != S_FAULT);
   assign fault = (cur == S_FAULT);
   assign state = cur;

`ifdef CTRL_PERF_EN
   always_ff @(posedge clock) begin
      if (!reset)
         retired <= '0;
      else if (end_instr)
         retired <= retired + 32'd1;
   end
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: a trace model pushes the expected
// per-cycle outputs of each randomized instruction, a monitor pops and compares.
module tb_multi_cycle_control;
   import ctrl_pkg::*;

   localparam int unsigned TO = 16;

   localparam logic [10:0] T_ADD  = 11'b100_0101_1000;
   localparam logic [10:0] T_SUB  = 11'b110_0101_1000;
   localparam logic [10:0] T_AND  = 11'b100_0101_0000;
   localparam logic [10:0] T_ORR  = 11'b101_0101_0000;
   localparam logic [10:0] T_LDUR = 11'b111_1100_0010;
   localparam logic [10:0] T_STUR = 11'b111_1100_0000;

   typedef enum int {K_R, K_LD, K_ST, K_CB, K_ILL} kind_t;

   typedef struct {
      logic [2:0] st;
      bit mem_req, ir_write, pc_write, pc_src, reg_to_loc, alu_src;
      bit mem_to_reg, reg_write, mem_read, mem_write, busy, fault;
      bit [1:0] alu_op;
      int unsigned ret;
      string tag;
   } rec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        run = 1'b0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic [10:0] opcode = '0;
   logic        mem_req, ir_write, pc_write, pc_src, reg_to_loc, alu_src;
   logic        mem_to_reg, reg_write, mem_read, mem_write, busy, fault;
   logic [1:0]  alu_op;
   logic [2:0]  state;
`ifdef CTRL_PERF_EN
   logic [31:0] retired;
`endif

   logic [10:0] probe = '0;
   class_t      probe_cls;
   logic [16:0] dut_v;

   rec_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   bit          in_fetch = 1'b0;
   int unsigned ret_exp = 0;

   always #5 clock = ~clock;

   multi_cycle_control #(.TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .reg_to_loc(reg_to_loc),
      .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
      .busy(busy), .fault(fault), .state(state)
`ifdef CTRL_PERF_EN
      , .retired(retired)
`endif
   );

   opcode_classifier u_ref_cls (.opcode(probe), .cls(probe_cls));

   assign dut_v = {state, mem_req, ir_write, pc_write, pc_src, reg_to_loc, alu_src,
                   mem_to_reg, reg_write, mem_read, mem_write, alu_op, busy, fault};

   function automatic logic [16:0] pack(input rec_t e);
      return {e.st, e.mem_req, e.ir_write, e.pc_write, e.pc_src, e.reg_to_loc, e.alu_src,
              e.mem_to_reg, e.reg_write, e.mem_read, e.mem_write, e.alu_op, e.busy, e.fault};
   endfunction

   function automatic kind_t ref_kind(input logic [10:0] op);
      if (op[10:3] == 8'b1011_0100) return K_CB;
      case (op)
         T_ADD, T_SUB, T_AND, T_ORR: return K_R;
         T_LDUR:                     return K_LD;
         T_STUR:                     return K_ST;
         default:                    return K_ILL;
      endcase
   endfunction

   function automatic class_t kind2cls(input kind_t k);
      case (k)
         K_R:     return CLS_R;
         K_LD:    return CLS_LD;
         K_ST:    return CLS_ST;
         K_CB:    return CLS_CB;
         default: return CLS_ILLEGAL;
      endcase
   endfunction

   function automatic bit rb();
      return 1'($urandom);
   endfunction

   function automatic logic [10:0] rop();
      return 11'($urandom);
   endfunction

   function automatic rec_t blank(input logic [2:0] st, input string tag);
      rec_t e;
      e = '{st: st, ret: ret_exp, tag: tag, default: '0};
      e.busy  = (st != S_IDLE) && (st != S_FAULT);
      e.fault = (st == S_FAULT);
      return e;
   endfunction

   // class-dependent datapath controls, valid from DECODE to the end of the instruction
   function automatic rec_t with_ctl(input rec_t e, input kind_t k);
      rec_t r = e;
      case (k)
         K_R:  r.alu_op = 2'b10;
         K_LD: r.alu_src = 1'b1;
         K_ST: begin r.alu_src = 1'b1; r.reg_to_loc = 1'b1; end
         K_CB: begin r.alu_op = 2'b01; r.reg_to_loc = 1'b1; end
         default: ;
      endcase
      return r;
   endfunction

   task automatic cyc(input rec_t e, input bit rst_n, input bit rn, input bit rdy,
                      input bit z, input logic [10:0] op);
      reset = rst_n; run = rn; mem_ready = rdy; zero = z; opcode = op;
      sb.push_back(e);
      @(posedge clock); #1;
   endtask

   task automatic finish_instr(input bit run_end);
      in_fetch = run_end;
      ret_exp  = ret_exp + 1;
   endtask

   task automatic fault_tail(input string why);
      rec_t e;
      for (int i = 0; i < 3; i++) begin
         e = blank(S_FAULT, why);
         cyc(e, 1'b1, 1'b1, rb(), rb(), rop());
      end
      e = blank(S_FAULT, "fault_reset");
      cyc(e, 1'b0, 1'b1, rb(), rb(), rop());
      in_fetch = 1'b0;
      ret_exp  = 0;
   endtask

   task automatic idle(input int n);
      rec_t e;
      if (in_fetch) return;
      for (int i = 0; i < n; i++) begin
         e = blank(S_IDLE, "idle");
         cyc(e, 1'b1, 1'b0, rb(), rb(), rop());
      end
   endtask

   // fw/mw: wait cycles before mem_ready in FETCH/MEMORY (>= TO means never ready)
   // abort_at: reset is asserted at that MEMORY wait index (-1 for none)
   task automatic do_instr(input logic [10:0] op, input bit z, input int unsigned fw,
                           input int unsigned mw, input bit run_end, input int abort_at);
      kind_t k = ref_kind(op);
      rec_t  e;
      if (!in_fetch) begin
         e = blank(S_IDLE, "idle_start");
         cyc(e, 1'b1, 1'b1, rb(), rb(), rop());
      end
      for (int unsigned i = 0; i < fw && i < TO; i++) begin
         e = blank(S_FETCH, "fetch_wait");
         e.mem_req = 1'b1; e.mem_read = 1'b1;
         cyc(e, 1'b1, rb(), 1'b0, rb(), rop());
      end
      if (fw >= TO) begin fault_tail("fetch_timeout"); return; end
      e = blank(S_FETCH, "fetch_ready");
      e.mem_req = 1'b1; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
      cyc(e, 1'b1, rb(), 1'b1, rb(), rop());

      e = with_ctl(blank(S_DECODE, "decode"), k);
      cyc(e, 1'b1, rb(), rb(), rb(), op);
      if (k == K_ILL) begin fault_tail("illegal"); return; end

      e = with_ctl(blank(S_EXECUTE, "execute"), k);
      if (k == K_CB) begin
         e.pc_write = z; e.pc_src = z;
         cyc(e, 1'b1, run_end, rb(), z, rop());
         finish_instr(run_end);
         return;
      end
      cyc(e, 1'b1, rb(), rb(), rb(), rop());

      if (k == K_LD || k == K_ST) begin
         for (int unsigned i = 0; i < mw && i < TO; i++) begin
            e = with_ctl(blank(S_MEMORY, "mem_wait"), k);
            e.mem_req = 1'b1; e.mem_read = (k == K_LD); e.mem_write = (k == K_ST);
            if (abort_at == int'(i)) begin
               cyc(e, 1'b0, 1'b1, 1'b0, rb(), rop());
               in_fetch = 1'b0;
               ret_exp  = 0;
               return;
            end
            cyc(e, 1'b1, rb(), 1'b0, rb(), rop());
         end
         if (mw >= TO) begin fault_tail("mem_timeout"); return; end
         e = with_ctl(blank(S_MEMORY, "mem_ready"), k);
         e.mem_req = 1'b1; e.mem_read = (k == K_LD); e.mem_write = (k == K_ST);
         if (k == K_ST) begin
            cyc(e, 1'b1, run_end, 1'b1, rb(), rop());
            finish_instr(run_end);
            return;
         end
         cyc(e, 1'b1, rb(), 1'b1, rb(), rop());
      end

      e = with_ctl(blank(S_WRITEBACK, "writeback"), k);
      e.reg_write = 1'b1; e.mem_to_reg = (k == K_LD);
      cyc(e, 1'b1, run_end, rb(), rb(), rop());
      finish_instr(run_end);
   endtask

   task automatic random_run(input int n);
      logic [10:0] op;
      int unsigned pick;
      for (int i = 0; i < n; i++) begin
         pick = $urandom_range(0, 9);
         case (pick)
            0, 9:    op = T_ADD;
            1:       op = T_SUB;
            2:       op = T_AND;
            3:       op = T_ORR;
            4:       op = T_LDUR;
            5:       op = T_STUR;
            6, 7:    op = {8'b1011_0100, 3'($urandom)};
            default: begin
               op = rop();
               while (ref_kind(op) != K_ILL) op = rop();
            end
         endcase
         do_instr(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3), rb(), -1);
         if (rb()) idle($urandom_range(1, 2));
      end
   endtask

   initial begin : monitor
      rec_t m;
      forever begin
         @(negedge clock);
         if (sb.size() != 0) begin
            m = sb.pop_front();
            checks++;
            if (pack(m) !== dut_v) begin
               errors++;
               $display("FAIL %s: got %05h required %05h (state got %0d required %0d)",
                        m.tag, dut_v, pack(m), state, m.st);
            end
`ifdef CTRL_PERF_EN
            checks++;
            if (retired !== m.ret) begin
               errors++;
               $display("FAIL retired@%s: got %0d required %0d", m.tag, retired, m.ret);
            end
`endif
         end
      end
   end

   initial begin : stimulus
      logic [10:0] probes [12];
      rec_t e;
      probes = '{T_ADD, T_SUB, T_AND, T_ORR, T_LDUR, T_STUR, 11'b101_1010_0000,
                 11'b101_1010_0111, 11'b000_0000_0000, 11'b101_1010_1000,
                 11'b111_1100_0011, 11'b100_0101_1001};
      for (int i = 0; i < 40; i++) begin
         if (i < 12)      probe = probes[i];
         else if (i < 24) probe = {8'b1011_0100, 3'($urandom)} ^ (rb() ? 11'h100 : 11'h000);
         else             probe = rop();
         #1;
         checks++;
         if (probe_cls !== kind2cls(ref_kind(probe))) begin
            errors++;
            $display("FAIL classify %03h: got %0d required %0d", probe,
                     probe_cls, kind2cls(ref_kind(probe)));
         end
      end

      @(posedge clock); #1;
      e = blank(S_IDLE, "reset_state");
      cyc(e, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      ret_exp = 0;
      idle(2);

      do_instr(T_ADD, 1'b0, 0, 0, 1'b0, -1);
      idle(1);
      do_instr(T_LDUR, 1'b0, 0, 3, 1'b1, -1);
      do_instr({8'b1011_0100, 3'b101}, 1'b1, 0, 0, 1'b1, -1);
      do_instr({8'b1011_0100, 3'b010}, 1'b0, 0, 0, 1'b1, -1);
      do_instr(T_SUB, 1'b1, 1, 0, 1'b0, -1);
      idle(3);
      do_instr(T_STUR, 1'b0, 0, 5, 1'b1, 1);
      do_instr(T_ADD, 1'b0, TO - 1, 0, 1'b1, -1);
      do_instr(T_STUR, 1'b0, 2, TO - 1, 1'b0, -1);
      do_instr(11'b000_0000_0000, 1'b0, 0, 0, 1'b1, -1);
      do_instr(T_ORR, 1'b0, TO, 0, 1'b1, -1);
      do_instr(T_LDUR, 1'b0, 0, TO, 1'b1, -1);

      random_run(40);
      do_instr(T_AND, 1'b0, 0, 0, 1'b0, -1);
      idle(2);

      @(negedge clock);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle sequencer for the LEGv8 datapath: it steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It drives the datapath strobes that the single-cycle control unit drives, plus the PC/IR write enables and a request/ready handshake to a shared memory port. It sits between the instruction register/ALU and the datapath multiplexers, register bank and memory. It replaces purely combinational control when fetch and data access share a slow memory.

## Interface
Parameters:
- TIMEOUT, 16, maximum consecutive cycles spent waiting on mem_ready before the block faults (must be ≥1).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; clears state on the clock edge while low
- run  in  1  permits starting a new instruction; sampled only at instruction boundaries
- opcode  in  11  instruction[31:21] from the IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completion for the current mem_req
- mem_req  out  1  memory access request
- ir_write, pc_write, pc_src  out  1 each  IR load; PC load; PC source (0 = PC+4, 1 = branch target)
- reg_to_loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write  out  1 each  datapath controls
- alu_op  out  2  {ALUOp1, ALUOp0}
- busy  out  1  high in every state except IDLE and FAULT
- fault  out  1  sticky error indicator
- state  out  3  current state encoding, for debug

## Operation
- **Instruction classes** (decoded from opcode in DECODE and latched until the instruction ends):
  - R: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - LD: LDUR 11111000010
  - ST: STUR 11111000000
  - CB: CBZ 10110100xxx
  - Any other opcode is ILLEGAL.
- **Class-dependent controls**, held from DECODE through the end of the instruction:
  - R: alu_op=10, alu_src=0, reg_to_loc=0
  - LD: alu_op=00, alu_src=1
  - ST: alu_op=00, alu_src=1, reg_to_loc=1
  - CB: alu_op=01, alu_src=0, reg_to_loc=1
- **States:** IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, FAULT.
- **IDLE** → FETCH if run=1; otherwise stay in IDLE.
- **FETCH:**
  - Drives mem_req=1 and mem_read=1.
  - In the cycle mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then → DECODE.
- **DECODE:** ILLEGAL → FAULT; otherwise → EXECUTE.
- **EXECUTE:**
  - R → WRITEBACK.
  - LD or ST → MEMORY.
  - CB: if zero=1, assert pc_write=1 and pc_src=1 for this cycle. Then end the instruction.
- **MEMORY:**
  - Drives mem_req=1, plus mem_read=1 (LD) or mem_write=1 (ST).
  - On mem_ready: LD → WRITEBACK; ST ends the instruction.
- **WRITEBACK:** reg_write=1, with mem_to_reg=1 for LD and 0 for R. Then end the instruction.
- **End of instruction:** → FETCH if run=1, else → IDLE.
- **Wait counter:**
  - Cleared on entry to FETCH or MEMORY, and on mem_ready.
  - Increments each cycle mem_ready=0 while in FETCH or MEMORY.
  - When it reaches TIMEOUT → FAULT.
  - If mem_ready=1 arrives in the same cycle the counter reaches TIMEOUT, mem_ready wins.
- **FAULT:**
  - All strobes are 0 and fault=1.
  - The only exit is reset.
- mem_ready is ignored outside FETCH and MEMORY.

## Timing
- Reset value of every output is 0; state resets to IDLE, and the counter and latched class are cleared.
- A reset asserted mid-instruction aborts it at that edge. Any partially completed access is discarded, and no write strobe is asserted in the following cycle.
- Control outputs are combinational from state, latched class, mem_ready and zero. Strobes in FETCH, MEMORY and EXECUTE are Mealy on mem_ready and zero.
- Latency from FETCH entry, with mem_ready=1 on the first request cycle:
  - R: 4 cycles
  - LD: 5 cycles
  - ST: 4 cycles
  - CB: 3 cycles
  - Each wait cycle adds 1.
- mem_req remains asserted until the cycle of mem_ready inclusive, then deasserts unless the next state also requests.
- Deasserting run never aborts an instruction in flight.

## Configuration
- CTRL_PERF_EN:
  - When defined, adds output retired[31:0]. It increments by 1 on each end-of-instruction cycle, wraps from 0xFFFFFFFF to 0, resets to 0, and holds in FAULT.
  - When undefined, the port and counter are absent and behaviour is otherwise identical.

## Structure
- Package ctrl_pkg holds:
  - the state enum with its 3-bit encoding;
  - the class enum (R, LD, ST, CB, ILLEGAL);
  - the opcode constants and CBZ mask;
  - the ALUOp constants.
- Sub-module opcode_classifier: combinational mapping from opcode to class. It is instantiated once and reused by the bench for reference checking.

## Test plan
- **ADD, mem_ready tied 1:** states FETCH, DECODE, EXECUTE, WRITEBACK. reg_write=1 only in cycle 4 with alu_op=10. retired increments by 1.
- **LDUR, mem_ready delayed 3 cycles in MEMORY:** mem_req high for 4 MEMORY cycles; then WRITEBACK with mem_to_reg=1. Total 8 cycles.
- **CBZ:** with zero=1, pc_write=1 and pc_src=1 in EXECUTE. With zero=0, no pc_write in EXECUTE. Both cases take 3 cycles.
- **Timeout:** opcode 00000000000 → FAULT after DECODE. Separately, mem_ready held 0 in FETCH with TIMEOUT=16 → FAULT after 16 wait cycles, fault=1 and all strobes 0.
- **Reset mid-operation:** reset low during MEMORY of STUR → next edge IDLE, mem_write=0, busy=0. Releasing reset with run=1 → FETCH.
- **run deasserted during EXECUTE of SUB:** WRITEBACK completes, then the block enters IDLE and mem_req stays 0.
